alu_datapath: RTL and testbench
===============================

Name: alu_datapath

Overview:
- Execute stage directly downstream of the instruction controller.
- Consumes enable, opcode (4b) and operands a, b (8b each) and executes the operation, single-cycle or iterative multi-cycle.
- Returns a registered WIDTH-bit result, then pulses done so the controller returns to its wait-for-go state.
- Holds a running accumulator for the ACC instruction.

Parameters:
- WIDTH, 16, result and accumulator width; must be at least 2*OPW.
- OPW, 8, operand width of a and b.
- ITER, 8, iteration count for MUL/DIV; must equal OPW.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  controller holds high, with opcode/a/b stable, until it sees done.
- opcode  in  4  operation select.
- a  in  OPW  operand A.
- b  in  OPW  operand B.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high while in EXEC_MUL, EXEC_DIV or DONE.
- result  out  WIDTH  last completed result, registered.
- err  out  1  sticky until next accepted op: invalid opcode or divide-by-zero.

Behaviour:
- Reset (async, active-high): state=IDLE; result, accumulator, done, busy, err, iteration counter and shift registers all 0. Reset mid-operation abandons the op; no done is issued.
- Opcodes:
  - 0000 ADD: result = zero-extended a + b.
  - 0001 SUB: result = a - b, two's-complement, WIDTH wide.
  - 0010 MUL: unsigned shift-add, result = a*b.
  - 0011 DIV: unsigned restoring divide, result = {remainder[OPW-1:0], quotient[OPW-1:0]}.
  - 1011 ACC: acc <= acc + a + b (operands zero-extended, wraps mod 2^WIDTH); result = new acc.
  - All others, including 1111: invalid.
- IDLE: enable sampled high means the op is accepted.
  - err clears on acceptance.
  - ADD, SUB, ACC and invalid: compute in the same edge; result registered (invalid leaves result unchanged and sets err); go to DONE.
  - MUL, DIV: latch operands, counter=0, go to EXEC_MUL or EXEC_DIV.
- EXEC_MUL / EXEC_DIV:
  - One shift/add or shift/subtract step per cycle; counter increments.
  - After ITER steps, write result and go to DONE.
  - DIV with b==0 skips iteration: quotient = all-ones, remainder = a, err=1, go to DONE.
  - enable low during EXEC aborts to IDLE; result unchanged; no done.
- DONE: done=1 for exactly one cycle; go to WAIT_REL.
- WAIT_REL: return to IDLE once enable==0. enable still high here is never re-accepted as a new op (no double execution).
- Latency from the accepting edge to done high:
  - ADD, SUB, ACC, invalid: 1 cycle.
  - MUL, DIV: ITER+1 cycles.
  - DIV by zero: 2 cycles.
- busy and done are registered outputs.
- Accumulator persists across ops; cleared only by reset.

Optional Feature:
- Macro ALU_DATAPATH_CARRY_EN.
- Defined: extra output port carry (1b), registered with result.
  - ADD: carry out of bit WIDTH-1, always 0 for 8-bit operands.
  - SUB: borrow, set when a < b.
  - ACC: carry out of the accumulator wrap.
  - MUL, DIV, invalid: carry = 0.
  - Cleared by reset.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [3:0] opcode_e {OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_ACC=4'b1011, OP_HALT=4'b1111}.
  - typedef enum state_e {IDLE, EXEC_MUL, EXEC_DIV, DONE, WAIT_REL}.
  - Localparam DIV_ZERO_Q = all-ones.
  - Shared with the controller for opcode decode.
- Sub-module alu_seq_unit: iterative MUL/DIV engine (start, mode, a, b -> valid, product/quotient/remainder). The top FSM handles the handshake and single-cycle ops.

Test Plan:
- Single-cycle ops: ADD a=0xFF b=0x01 -> result=0x0100, done exactly 1 cycle after accept; SUB a=0x03 b=0x05 -> result=0xFFFE (carry=1 if ALU_DATAPATH_CARRY_EN).
- MUL: a=0xFF b=0xFF -> result=0xFE01, done at cycle ITER+1=9, busy high throughout.
- DIV: a=100 b=7 -> result=0x020E (rem 2, quot 14); a=0x55 b=0 -> result=0x55FF, err=1, done after 2 cycles.
- ACC: ACC(3,4) then ACC(0x10,0x20) -> result 0x0007 then 0x0037; async reset, then ACC(1,1) -> 0x0002.
- Handshake and invalid ops: enable held high 5 cycles after done -> no second done. Opcode 0x5 and 0xF -> err=1, result unchanged, done after 1 cycle.
- Aborts: enable dropped at MUL step 4 -> no done, result unchanged, IDLE next cycle. Reset asserted mid-DIV -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the execute stage and its controller.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_ACC  = 4'b1011,
        OP_HALT = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        EXEC_MUL,
        EXEC_DIV,
        DONE,
        WAIT_REL
    } state_e;

    // Quotient reported for a divide by zero; sliced to the operand width by users.
    localparam logic [31:0] DIV_ZERO_Q = '1;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_unit.sv
// Iterative engine: unsigned shift-add multiply and restoring divide, one step per cycle.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int OPW  = 8,
    parameter int ITER = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic             div_mode,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             valid,
    output logic             div_zero,
    output logic [2*OPW-1:0] product,
    output logic [OPW-1:0]   quotient,
    output logic [OPW-1:0]   remainder
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    logic           running_reg;
    logic           div_reg;
    logic [CW-1:0]  count_reg;
    // hi: partial product / partial remainder; lo: multiplier / dividend-quotient
    logic [OPW-1:0] hi_reg;
    logic [OPW-1:0] lo_reg;
    logic [OPW-1:0] op_reg;

    logic [OPW-1:0] hi_next;
    logic [OPW-1:0] lo_next;
    logic [OPW:0]   mul_sum;
    logic [OPW:0]   div_trial;
    logic [OPW:0]   div_diff;
    logic           last_step;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + ({(OPW+1){lo_reg[0]}} & {1'b0, op_reg});
        div_trial = {hi_reg, lo_reg[OPW-1]};
        div_diff  = div_trial - {1'b0, op_reg};
        hi_next   = hi_reg;
        lo_next   = lo_reg;
        if (div_reg) begin
            // The partial remainder is always below the divisor, so the top bit is a clean borrow.
            if (!div_diff[OPW]) begin
                hi_next = div_diff[OPW-1:0];
                lo_next = {lo_reg[OPW-2:0], 1'b1};
            end else begin
                hi_next = div_trial[OPW-1:0];
                lo_next = {lo_reg[OPW-2:0], 1'b0};
            end
        end else begin
            hi_next = mul_sum[OPW:1];
            lo_next = {mul_sum[0], lo_reg[OPW-1:1]};
        end
    end

    assign div_zero  = div_reg && (op_reg == '0);
    assign last_step = (count_reg == CW'(ITER - 1));
    assign valid     = running_reg && (last_step || div_zero);
    assign product   = {hi_next, lo_next};
    assign quotient  = div_zero ? DIV_ZERO_Q[OPW-1:0] : lo_next;
    assign remainder = div_zero ? lo_reg : hi_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running_reg <= 1'b0;
            div_reg     <= 1'b0;
            count_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            op_reg      <= '0;
        end else if (start) begin
            running_reg <= 1'b1;
            div_reg     <= div_mode;
            count_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= div_mode ? a : b;
            op_reg      <= div_mode ? b : a;
        end else if (running_reg) begin
            if (cancel || valid) begin
                running_reg <= 1'b0;
            end else begin
                hi_reg    <= hi_next;
                lo_reg    <= lo_next;
                count_reg <= count_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_datapath.sv
// Execute stage: enable/done handshake, single-cycle ops, accumulator, iterative MUL/DIV.
// Optional carry output enabled by defining ALU_DATAPATH_CARRY_EN.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 8,
    parameter int ITER  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       opcode,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] result,
`ifdef ALU_DATAPATH_CARRY_EN
    output logic             carry,
`endif
    output logic             err
);

`ifdef ALU_DATAPATH_CARRY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic             err_reg, err_next;
    logic             done_reg;
    logic             busy_reg;
`ifdef ALU_DATAPATH_CARRY_EN
    logic             carry_reg, carry_next;
`endif

    logic [SW-1:0]    add_full;
    logic [SW-1:0]    acc_full;
    logic [WIDTH-1:0] sub_res;

    logic             seq_start;
    logic             seq_cancel;
    logic             seq_valid;
    logic             seq_div_zero;
    logic [2*OPW-1:0] seq_product;
    logic [OPW-1:0]   seq_quotient;
    logic [OPW-1:0]   seq_remainder;

    alu_seq_unit #(
        .OPW  (OPW),
        .ITER (ITER)
    ) u_seq (
        .clk       (clk),
        .reset     (reset),
        .start     (seq_start),
        .cancel    (seq_cancel),
        .div_mode  (opcode == OP_DIV),
        .a         (a),
        .b         (b),
        .valid     (seq_valid),
        .div_zero  (seq_div_zero),
        .product   (seq_product),
        .quotient  (seq_quotient),
        .remainder (seq_remainder)
    );

    assign add_full = SW'(a) + SW'(b);
    assign acc_full = SW'(acc_reg) + SW'(a) + SW'(b);
    assign sub_res  = WIDTH'(a) - WIDTH'(b);

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        acc_next    = acc_reg;
        err_next    = err_reg;
`ifdef ALU_DATAPATH_CARRY_EN
        carry_next  = carry_reg;
`endif
        seq_start   = 1'b0;
        seq_cancel  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    err_next = 1'b0;
`ifdef ALU_DATAPATH_CARRY_EN
                    carry_next = 1'b0;
`endif
                    if (is_iterative(opcode)) begin
                        seq_start  = 1'b1;
                        state_next = (opcode == OP_DIV) ? EXEC_DIV : EXEC_MUL;
                    end else begin
                        state_next = DONE;
                        case (opcode)
                            OP_ADD: begin
                                result_next = add_full[WIDTH-1:0];
`ifdef ALU_DATAPATH_CARRY_EN
                                carry_next  = add_full[SW-1];
`endif
                            end
                            OP_SUB: begin
                                result_next = sub_res;
`ifdef ALU_DATAPATH_CARRY_EN
                                carry_next  = (a < b);
`endif
                            end
                            OP_ACC: begin
                                acc_next    = acc_full[WIDTH-1:0];
                                result_next = acc_full[WIDTH-1:0];
`ifdef ALU_DATAPATH_CARRY_EN
                                carry_next  = acc_full[SW-1];
`endif
                            end
                            default: err_next = 1'b1;
                        endcase
                    end
                end
            end
            EXEC_MUL, EXEC_DIV: begin
                // Controller withdrawing enable abandons the op silently.
                if (!enable) begin
                    seq_cancel = 1'b1;
                    state_next = IDLE;
                end else if (seq_valid) begin
                    state_next = DONE;
                    if (state_reg == EXEC_MUL) begin
                        result_next = WIDTH'(seq_product);
                    end else begin
                        result_next = WIDTH'({seq_remainder, seq_quotient});
                        err_next    = seq_div_zero;
                    end
                end
            end
            DONE: state_next = WAIT_REL;
            WAIT_REL: begin
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            acc_reg    <= '0;
            err_reg    <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
`ifdef ALU_DATAPATH_CARRY_EN
            carry_reg  <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            acc_reg    <= acc_next;
            err_reg    <= err_next;
            done_reg   <= (state_next == DONE);
            busy_reg   <= (state_next == EXEC_MUL) || (state_next == EXEC_DIV) ||
                          (state_next == DONE);
`ifdef ALU_DATAPATH_CARRY_EN
            carry_reg  <= carry_next;
`endif
        end
    end

    assign done   = done_reg;
    assign busy   = busy_reg;
    assign result = result_reg;
    assign err    = err_reg;
`ifdef ALU_DATAPATH_CARRY_EN
    assign carry  = carry_reg;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// Scoreboard bench for alu_datapath: handshake, latency, all ops, aborts and async reset.
module tb_alu_datapath;

    localparam int W     = 16;
    localparam int OPW_T = 8;
    localparam int ITER_T = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [3:0]     opcode;
    logic [OPW_T-1:0] a;
    logic [OPW_T-1:0] b;
    logic           done;
    logic           busy;
    logic [W-1:0]   result;
    logic           err;
`ifdef ALU_DATAPATH_CARRY_EN
    logic           carry;
`endif

    alu_datapath #(
        .WIDTH (W),
        .OPW   (OPW_T),
        .ITER  (ITER_T)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .done   (done),
        .busy   (busy),
        .result (result),
`ifdef ALU_DATAPATH_CARRY_EN
        .carry  (carry),
`endif
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;
        logic         cy;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model_acc = '0;
    logic [W-1:0] model_result = '0;
    logic [3:0]   ops_tab [6];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_expected(input logic [3:0] op, input logic [7:0] xa, input logic [7:0] xb);
        exp_t e;
        logic [W:0] wide;
        e.res = model_result;
        e.err = 1'b0;
        e.lat = 1;
        e.cy  = 1'b0;
        case (op)
            4'h0: e.res = W'(xa) + W'(xb);
            4'h1: begin
                e.res = W'(xa) - W'(xb);
                e.cy  = (xa < xb);
            end
            4'h2: begin
                e.res = W'(xa) * W'(xb);
                e.lat = ITER_T + 1;
            end
            4'h3: begin
                if (xb == 8'h00) begin
                    e.res = {xa, 8'hFF};
                    e.err = 1'b1;
                    e.lat = 2;
                end else begin
                    e.res = {8'(xa % xb), 8'(xa / xb)};
                    e.lat = ITER_T + 1;
                end
            end
            4'hB: begin
                wide      = (W+1)'(model_acc) + (W+1)'(xa) + (W+1)'(xb);
                model_acc = wide[W-1:0];
                e.res     = wide[W-1:0];
                e.cy      = wide[W];
            end
            default: e.err = 1'b1;
        endcase
        model_result = e.res;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [7:0] xa, input logic [7:0] xb,
                          input int hold);
        exp_t e;
        int   cyc;
        int   redone;
        bit   got_done;
        bit   busy_gap;
        push_expected(op, xa, xb);
        @(negedge clk);
        opcode = op;
        a      = xa;
        b      = xb;
        enable = 1'b1;
        cyc      = 0;
        got_done = 1'b0;
        busy_gap = 1'b0;
        while (!got_done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) got_done = 1'b1;
            else if (!busy) busy_gap = 1'b1;
        end
        e = sb.pop_front();
        if (!got_done) begin
            check_val("done_timeout", 32'd0, 32'd1);
        end else begin
            check_val("result", 32'(result), 32'(e.res));
            check_val("err", 32'(err), 32'(e.err));
            check_val("latency", 32'(cyc), 32'(e.lat));
            check_val("busy_at_done", 32'(busy), 32'd1);
            check_val("busy_gap", 32'(busy_gap), 32'd0);
`ifdef ALU_DATAPATH_CARRY_EN
            check_val("carry", 32'(carry), 32'(e.cy));
`endif
        end
        $display("op=%h a=%h b=%h result=%h err=%b latency=%0d", op, xa, xb, result, err, cyc);
        redone = 0;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (done) redone++;
        end
        check_val("single_done", 32'(redone), 32'd0);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int idx;
        int stray;
        ops_tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hB, 4'h7};
        reset  = 1'b1;
        enable = 1'b0;
        opcode = 4'h0;
        a      = '0;
        b      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_result", 32'(result), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(4'h0, 8'hFF, 8'h01, 1);
        run_op(4'h1, 8'h03, 8'h05, 1);
        run_op(4'h2, 8'hFF, 8'hFF, 1);
        run_op(4'h3, 8'd100, 8'd7, 1);
        run_op(4'h3, 8'h55, 8'h00, 1);
        run_op(4'h0, 8'h12, 8'h34, 1);
        run_op(4'hB, 8'h03, 8'h04, 1);
        run_op(4'hB, 8'h10, 8'h20, 1);
        run_op(4'h0, 8'h20, 8'h30, 5);
        run_op(4'h5, 8'h01, 8'h02, 1);
        run_op(4'hF, 8'h09, 8'h09, 1);
        run_op(4'h1, 8'h80, 8'h01, 1);

        for (int i = 0; i < 12; i++) begin
            idx = $urandom_range(0, 5);
            run_op(ops_tab[idx], 8'($urandom), 8'($urandom), 1);
        end

        // MUL abandoned at its fourth step: no done, result untouched.
        @(negedge clk);
        opcode = 4'h2;
        a      = 8'h0F;
        b      = 8'h0E;
        enable = 1'b1;
        stray  = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) stray++;
        end
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_result", 32'(result), 32'(model_result));
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) stray++;
        end
        check_val("abort_no_done", 32'(stray), 32'd0);
        $display("op=2 aborted result=%h", result);
        run_op(4'h0, 8'h11, 8'h22, 1);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        opcode = 4'h3;
        a      = 8'd100;
        b      = 8'd7;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_result", 32'(result), 32'd0);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        check_val("arst_err", 32'(err), 32'd0);
        $display("op=3 reset mid-divide result=%h", result);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset        = 1'b0;
        model_acc    = '0;
        model_result = '0;
        stray = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) stray++;
        end
        check_val("arst_no_done", 32'(stray), 32'd0);
        run_op(4'hB, 8'h01, 8'h01, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
